// File: rtl/nanosoc_rstctrl_pkg.sv
// nanoSoC reset-request controller: shared constants and types.
package nanosoc_rstctrl_pkg;

    localparam int unsigned OFF_CTRL   = 32'h000;
    localparam int unsigned OFF_MASK   = 32'h004;
    localparam int unsigned OFF_CAUSE  = 32'h008;
    localparam int unsigned OFF_SWRST  = 32'h00C;
    localparam int unsigned OFF_STATUS = 32'h010;

    localparam logic [7:0] SWRST_KEY     = 8'h5A;
    localparam int         CAUSE_SW_BIT  = 16;
    localparam int         STRETCH_RESET = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/nanosoc_rstctrl_apb_regs.sv
// APB decode plus CTRL, MASK and sticky CAUSE registers.
module nanosoc_rstctrl_apb_regs
    import nanosoc_rstctrl_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int STRETCH_W  = 8,
    parameter int APB_ADDR_W = 12,
    parameter int APB_DATA_W = 32,
    parameter logic [NUM_SRC-1:0] MASK_RESET = NUM_SRC'(4'hF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pslverr,
    input  logic [NUM_SRC-1:0]    cause_set,
    input  state_e                state,
    input  logic [STRETCH_W-1:0]  count,
    output logic [STRETCH_W-1:0]  stretch,
    output logic [NUM_SRC-1:0]    mask,
    output logic                  sw_req,
    output logic                  cause_valid
);

    logic [APB_ADDR_W-3:0] word;
    logic                  access;
    logic                  wr;
    logic                  rd;
    logic                  sel_ctrl;
    logic                  sel_mask;
    logic                  sel_cause;
    logic                  sel_swrst;
    logic                  sel_status;
    logic                  hit;
    logic [STRETCH_W-1:0]  stretch_q, stretch_d;
    logic [NUM_SRC-1:0]    mask_q, mask_d;
    logic [NUM_SRC-1:0]    hw_cause_q, hw_cause_d;
    logic                  sw_cause_q, sw_cause_d;
    logic [APB_DATA_W-1:0] rdata;
    logic                  unused_bits;

    assign word       = paddr[APB_ADDR_W-1:2];
    assign access     = psel & penable;
    assign wr         = access & pwrite;
    assign rd         = access & ~pwrite;
    assign sel_ctrl   = word == (APB_ADDR_W-2)'(OFF_CTRL >> 2);
    assign sel_mask   = word == (APB_ADDR_W-2)'(OFF_MASK >> 2);
    assign sel_cause  = word == (APB_ADDR_W-2)'(OFF_CAUSE >> 2);
    assign sel_swrst  = word == (APB_ADDR_W-2)'(OFF_SWRST >> 2);
    assign sel_status = word == (APB_ADDR_W-2)'(OFF_STATUS >> 2);
    assign hit        = sel_ctrl | sel_mask | sel_cause | sel_swrst | sel_status;
    assign pslverr    = access & ~hit;
    assign sw_req     = wr & sel_swrst & (pwdata[7:0] == SWRST_KEY);
    assign unused_bits = ^{paddr[1:0], pwdata};

    // New cause bits are OR-ed in after the W1C mask, so a set wins.
    always_comb begin
        stretch_d  = stretch_q;
        mask_d     = mask_q;
        hw_cause_d = hw_cause_q | cause_set;
        sw_cause_d = sw_cause_q | sw_req;
        if (wr & sel_ctrl)
            stretch_d = pwdata[8 +: STRETCH_W];
        if (wr & sel_mask)
            mask_d = pwdata[NUM_SRC-1:0];
        if (wr & sel_cause) begin
            hw_cause_d = (hw_cause_q & ~pwdata[NUM_SRC-1:0]) | cause_set;
            sw_cause_d = (sw_cause_q & ~pwdata[CAUSE_SW_BIT]) | sw_req;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ctrl:   rdata[8 +: STRETCH_W] = stretch_q;
            sel_mask:   rdata[NUM_SRC-1:0] = mask_q;
            sel_cause: begin
                rdata[NUM_SRC-1:0]  = hw_cause_q;
                rdata[CAUSE_SW_BIT] = sw_cause_q;
            end
            sel_status: begin
                rdata[1:0]          = state;
                rdata[16 +: STRETCH_W] = count;
            end
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch_q  <= STRETCH_W'(STRETCH_RESET);
            mask_q     <= MASK_RESET;
            hw_cause_q <= '0;
            sw_cause_q <= 1'b0;
        end else begin
            stretch_q  <= stretch_d;
            mask_q     <= mask_d;
            hw_cause_q <= hw_cause_d;
            sw_cause_q <= sw_cause_d;
        end
    end

    assign prdata      = rd ? rdata : '0;
    assign stretch     = stretch_q;
    assign mask        = mask_q;
    assign cause_valid = (|hw_cause_q) | sw_cause_q;

endmodule

// File: rtl/nanosoc_rstctrl_gen.sv
// nanoSoC reset-request controller: trigger FSM and stretch counter.
module nanosoc_rstctrl_gen
    import nanosoc_rstctrl_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int STRETCH_W  = 8,
    parameter int APB_ADDR_W = 12,
    parameter int APB_DATA_W = 32,
    parameter logic [NUM_SRC-1:0] MASK_RESET = NUM_SRC'(4'hF)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [NUM_SRC-1:0]    RST_SRC_REQ,
    output logic                  SYS_RESET_REQ,
    output logic                  RST_BUSY,
    output logic                  CAUSE_VALID
);

    state_e               state_q, state_d;
    logic [STRETCH_W-1:0] cnt_q, cnt_d;
    logic                 sys_req_q, sys_req_d;
    logic                 busy_q, busy_d;
    logic [STRETCH_W-1:0] stretch;
    logic [NUM_SRC-1:0]   mask;
    logic [NUM_SRC-1:0]   masked;
    logic                 sw_req;
    logic                 trig;

    assign PREADY = 1'b1;
    assign masked = RST_SRC_REQ & mask;
    assign trig   = (|masked) | sw_req;

    nanosoc_rstctrl_apb_regs #(
        .NUM_SRC    (NUM_SRC),
        .STRETCH_W  (STRETCH_W),
        .APB_ADDR_W (APB_ADDR_W),
        .APB_DATA_W (APB_DATA_W),
        .MASK_RESET (MASK_RESET)
    ) u_regs (
        .clk         (HCLK),
        .rst         (HRESET),
        .psel        (PSEL),
        .penable     (PENABLE),
        .pwrite      (PWRITE),
        .paddr       (PADDR),
        .pwdata      (PWDATA),
        .prdata      (PRDATA),
        .pslverr     (PSLVERR),
        .cause_set   (masked),
        .state       (state_q),
        .count       (cnt_q),
        .stretch     (stretch),
        .mask        (mask),
        .sw_req      (sw_req),
        .cause_valid (CAUSE_VALID)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    cnt_d   = (stretch == '0) ? STRETCH_W'(1) : stretch;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                cnt_d = cnt_q - STRETCH_W'(1);
                if (cnt_q == STRETCH_W'(1))
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (masked == '0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs follow the next state so they line up with state_q.
        sys_req_d = (state_d == ST_ASSERT);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sys_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sys_req_q <= sys_req_d;
            busy_q    <= busy_d;
        end
    end

    assign SYS_RESET_REQ = sys_req_q;
    assign RST_BUSY      = busy_q;

endmodule

// File: tb/tb_nanosoc_rstctrl_gen.sv
// Bench for nanosoc_rstctrl_gen: directed stimulus fills expectation
// queues that a single negedge monitor drains and compares.
module tb_nanosoc_rstctrl_gen;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  RST_SRC_REQ;
    logic        SYS_RESET_REQ;
    logic        RST_BUSY;
    logic        CAUSE_VALID;

    typedef struct { string nm; logic [31:0] data; logic err; } apb_exp_t;
    typedef struct { int start; int len; } pulse_exp_t;
    typedef struct { string nm; int at; logic [2:0] val; } lvl_exp_t;

    apb_exp_t   apb_q[$];
    pulse_exp_t pulse_q[$];
    lvl_exp_t   lvl_q[$];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    bit done = 1'b0;
    int acc;
    int c0;

    apb_exp_t   e;
    pulse_exp_t p;
    lvl_exp_t   l;
    logic       prev_req = 1'b0;
    int         p_start = 0;

    nanosoc_rstctrl_gen dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .RST_SRC_REQ   (RST_SRC_REQ),
        .SYS_RESET_REQ (SYS_RESET_REQ),
        .RST_BUSY      (RST_BUSY),
        .CAUSE_VALID   (CAUSE_VALID)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic apb(input logic wr, input logic [11:0] a,
                       input logic [31:0] wd, input string nm,
                       input logic [31:0] ed, input logic ee);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
        step(1);
        PENABLE = 1'b1;
        acc = cyc;
        apb_q.push_back('{nm, ed, ee});
        step(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input string nm, input logic [31:0] ed);
        apb(1'b0, a, 32'h0, nm, ed, 1'b0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] wd, input string nm);
        apb(1'b1, a, wd, nm, 32'h0, 1'b0);
    endtask

    // val = {SYS_RESET_REQ, RST_BUSY, CAUSE_VALID} at this cycle's negedge
    task automatic expect_lvl(input string nm, input logic [2:0] val);
        lvl_q.push_back('{nm, cyc, val});
    endtask

    task automatic expect_pulse(input int start, input int len);
        pulse_q.push_back('{start, len});
    endtask

    always @(negedge HCLK) begin
        if (!HRESET && PSEL && PENABLE) begin
            if (apb_q.size() == 0) begin
                n_total++;
                $display("FAIL apb_unexpected: got access at cyc %0d, want none", cyc);
            end else begin
                e = apb_q.pop_front();
                chk({e.nm, "_rdata"}, PRDATA, e.data);
                chk({e.nm, "_err"}, {31'b0, PSLVERR}, {31'b0, e.err});
            end
        end
        if (SYS_RESET_REQ && !prev_req) p_start = cyc;
        if (!SYS_RESET_REQ && prev_req) begin
            if (pulse_q.size() == 0) begin
                n_total++;
                $display("FAIL pulse_unexpected: got start %0d len %0d, want none",
                         p_start, cyc - p_start);
            end else begin
                p = pulse_q.pop_front();
                chk("pulse_start", p_start, p.start);
                chk("pulse_len", cyc - p_start, p.len);
            end
        end
        prev_req = SYS_RESET_REQ;
        while (lvl_q.size() > 0 && lvl_q[0].at <= cyc) begin
            l = lvl_q.pop_front();
            chk(l.nm, {29'b0, SYS_RESET_REQ, RST_BUSY, CAUSE_VALID}, {29'b0, l.val});
        end
        if (done || cyc > 6000) begin
            if (!done) begin
                n_total++;
                $display("FAIL timeout: got cyc %0d, want done", cyc);
            end
            chk("apb_q_left", 32'(apb_q.size()), 32'd0);
            chk("pulse_q_left", 32'(pulse_q.size()), 32'd0);
            chk("lvl_q_left", 32'(lvl_q.size()), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    initial begin
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; RST_SRC_REQ = '0;
        step(3);
        HRESET = 1'b0;
        expect_lvl("rst_outputs", 3'b000);
        rd(12'h000, "rst_ctrl", 32'h1000);
        rd(12'h004, "rst_mask", 32'hF);
        rd(12'h008, "rst_cause", 32'h0);
        rd(12'h00C, "rst_swrst", 32'h0);
        rd(12'h010, "rst_status", 32'h0);

        RST_SRC_REQ = 4'b0100;
        expect_pulse(cyc + 1, 16);
        step(1);
        RST_SRC_REQ = '0;
        expect_lvl("src2_assert", 3'b111);
        step(20);
        expect_lvl("src2_done", 3'b001);
        rd(12'h008, "src2_cause", 32'h4);
        rd(12'h010, "src2_status", 32'h0);
        wr(12'h008, 32'h4, "cause_w1c");
        rd(12'h008, "cause_cleared", 32'h0);
        expect_lvl("cause_clr_valid", 3'b000);

        wr(12'h004, 32'hE, "mask_wr");
        rd(12'h004, "mask_rd", 32'hE);
        RST_SRC_REQ = 4'b0001;
        step(5);
        expect_lvl("masked_src0", 3'b000);
        RST_SRC_REQ = 4'b1001;
        expect_pulse(cyc + 1, 16);
        step(1);
        RST_SRC_REQ = '0;
        step(20);
        rd(12'h008, "src03_cause", 32'h8);
        wr(12'h008, 32'hFFFF_FFFF, "cause_clr_all");

        wr(12'h000, 32'h0, "ctrl_zero");
        rd(12'h000, "ctrl_rd0", 32'h0);
        wr(12'h00C, 32'h5A, "swrst_key");
        expect_pulse(acc + 1, 1);
        step(4);
        rd(12'h008, "sw_cause", 32'h1_0000);
        wr(12'h00C, 32'h33, "swrst_bad");
        step(20);
        rd(12'h00C, "swrst_rd", 32'h0);
        wr(12'h008, 32'h1_0000, "sw_w1c");
        rd(12'h008, "sw_cleared", 32'h0);
        wr(12'h010, 32'hFFFF_FFFF, "status_wr");
        rd(12'h010, "status_ro", 32'h0);

        wr(12'h000, 32'h400, "ctrl_s4");
        RST_SRC_REQ = 4'b0010;
        c0 = cyc;
        expect_pulse(c0 + 1, 4);
        step(1);
        expect_lvl("hold_assert", 3'b111);
        step(20);
        expect_lvl("hold_wait", 3'b011);
        rd(12'h010, "hold_status", 32'h2);
        step(c0 + 40 - cyc);
        RST_SRC_REQ = '0;
        expect_lvl("hold_drop", 3'b011);
        step(1);
        expect_lvl("hold_exit", 3'b001);
        step(10);
        rd(12'h008, "hold_cause", 32'h2);

        RST_SRC_REQ = 4'b0010;
        c0 = cyc;
        step(1);
        RST_SRC_REQ = '0;
        step(1);
        HRESET = 1'b1;
        expect_pulse(c0 + 1, 1);
        expect_lvl("hreset_out", 3'b000);
        step(2);
        HRESET = 1'b0;
        step(1);
        rd(12'h008, "post_rst_cause", 32'h0);
        rd(12'h000, "post_rst_ctrl", 32'h1000);
        rd(12'h004, "post_rst_mask", 32'hF);
        apb(1'b0, 12'h020, 32'h0, "unmapped_rd", 32'h0, 1'b1);
        apb(1'b1, 12'h020, 32'hFFFF_FFFF, "unmapped_wr", 32'h0, 1'b1);
        rd(12'h004, "mask_after_unmapped", 32'hF);
        step(2);
        done = 1'b1;
    end

endmodule
